// File: rtl/adc_scan_ctrl.sv
// adc_scan_ctrl: multi-channel SPI scan controller for AD7888-class 8-channel ADCs.
// Derives SCLK/CS/DIN from i_sclk, shifts 16-bit frames, walks the enabled
// channel mask (single-shot or continuous) and returns channel-tagged results
// over a valid/ready interface. ADC results lag one frame behind the address.
module adc_scan_ctrl #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned DATA_W  = 12,
  parameter int unsigned CS_GAP  = 2,
  parameter int unsigned REF_BIT = 0
) (
  input  logic              i_sclk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_cont,
  input  logic              i_stop,
  input  logic [7:0]        i_ch_mask,
  output logic              o_busy,
  output logic              o_done,
  output logic [DATA_W-1:0] o_data,
  output logic [2:0]        o_ch,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_overrun,
  output logic              o_spi_sclk,
  output logic              o_spi_cs,
  output logic              o_spi_dout,
  input  logic              i_spi_din
);

  localparam int unsigned FRAME_W = 16;
  localparam int unsigned HALF    = CLK_DIV / 2;
  localparam int unsigned CNT_MAX = (HALF > CS_GAP) ? HALF : CS_GAP;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned BIT_W   = $clog2(FRAME_W);
  localparam int unsigned NCH_W   = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_GAP
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [BIT_W-1:0]     bit_idx;
  logic [FRAME_W-1:0]   tx;
  logic [DATA_W-1:0]    shreg;
  logic [7:0]           mask;
  logic                 cont;
  logic                 stop_req;
  logic                 flush;
  logic                 first;
  logic [NCH_W-1:0]     frames_left;
  logic [2:0]           cur_addr;
  logic [2:0]           prev_addr;

  logic [2:0]           nxt_addr;
  logic [FRAME_W-1:0]   nxt_word;
  logic                 stop_now;
  logic                 scan_last;

  // Lowest enabled channel of a mask (0 when the mask is empty).
  function automatic logic [2:0] first_ch(input logic [7:0] m);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) r = 3'(i);
    end
    return r;
  endfunction

  // Next enabled channel above c, wrapping to the lowest one.
  function automatic logic [2:0] next_ch(input logic [7:0] m, input logic [2:0] c);
    logic [2:0] r;
    r = first_ch(m);
    for (int i = 7; i >= 0; i--) begin
      if (m[i] && (i > int'(c))) r = 3'(i);
    end
    return r;
  endfunction

  // Number of enabled channels.
  function automatic logic [NCH_W-1:0] count_ch(input logic [7:0] m);
    logic [NCH_W-1:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + NCH_W'(m[i]);
    end
    return n;
  endfunction

  // ADC control word for a channel address.
  function automatic logic [FRAME_W-1:0] frame_word(input logic [2:0] a);
    return {2'b00, a, 1'(REF_BIT), 2'b00, 8'h00};
  endfunction

  // Address and control word of the frame about to start.
  always_comb begin
    nxt_addr = (state == S_IDLE) ? first_ch(i_ch_mask) : next_ch(mask, cur_addr);
    nxt_word = frame_word(nxt_addr);
  end

  // End-of-scan decision taken when the inter-frame gap expires.
  always_comb begin
    stop_now  = stop_req | i_stop;
    scan_last = 1'b0;
    if (cont) begin
      scan_last = flush;
    end else begin
      scan_last = (frames_left == '0) || stop_now;
    end
  end

  // Scan FSM with SPI pin generation, result capture and handshake.
  always_ff @(posedge i_sclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      tx          <= '0;
      shreg       <= '0;
      mask        <= '0;
      cont        <= 1'b0;
      stop_req    <= 1'b0;
      flush       <= 1'b0;
      first       <= 1'b0;
      frames_left <= '0;
      cur_addr    <= '0;
      prev_addr   <= '0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_data      <= '0;
      o_ch        <= '0;
      o_valid     <= 1'b0;
      o_overrun   <= 1'b0;
      o_spi_sclk  <= 1'b1;
      o_spi_cs    <= 1'b1;
      o_spi_dout  <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (o_valid && i_ready) o_valid <= 1'b0;
      if (i_stop && (state != S_IDLE)) stop_req <= 1'b1;

      case (state)
        S_IDLE: begin
          if (i_start) begin
            if (i_ch_mask != 8'h00) begin
              mask        <= i_ch_mask;
              cont        <= i_cont;
              frames_left <= count_ch(i_ch_mask) + NCH_W'(1);
              stop_req    <= 1'b0;
              flush       <= 1'b0;
              first       <= 1'b1;
              o_overrun   <= 1'b0;
              o_busy      <= 1'b1;
              cur_addr    <= nxt_addr;
              prev_addr   <= nxt_addr;
              tx          <= nxt_word;
              o_spi_dout  <= nxt_word[FRAME_W-1];
              o_spi_cs    <= 1'b0;
              cnt         <= '0;
              state       <= S_SETUP;
            end else begin
              o_done <= 1'b1;
            end
          end
        end

        // CS low, SCLK high, MSB presented before the first falling edge.
        S_SETUP: begin
          if (cnt == CNT_W'(HALF - 1)) begin
            cnt        <= '0;
            bit_idx    <= '0;
            o_spi_sclk <= 1'b0;
            o_spi_dout <= tx[FRAME_W-1];
            state      <= S_SHIFT;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        // Falling edge drives DIN, rising edge captures DOUT.
        S_SHIFT: begin
          if (cnt == CNT_W'(HALF - 1)) begin
            cnt <= '0;
            if (!o_spi_sclk) begin
              o_spi_sclk <= 1'b1;
              shreg      <= {shreg[DATA_W-2:0], i_spi_din};
            end else if (bit_idx == BIT_W'(FRAME_W - 1)) begin
              state <= S_HOLD;
            end else begin
              o_spi_sclk <= 1'b0;
              o_spi_dout <= tx[FRAME_W-2];
              tx         <= {tx[FRAME_W-2:0], 1'b0};
              bit_idx    <= bit_idx + BIT_W'(1);
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        // SCLK stays high, then CS releases and the previous address's data lands.
        S_HOLD: begin
          if (cnt == CNT_W'(HALF - 1)) begin
            cnt         <= '0;
            o_spi_cs    <= 1'b1;
            o_spi_dout  <= 1'b0;
            frames_left <= frames_left - NCH_W'(frames_left != '0);
            state       <= S_GAP;
            if (!first) begin
              o_data  <= shreg;
              o_ch    <= prev_addr;
              o_valid <= 1'b1;
              if (o_valid && !i_ready) o_overrun <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        // CS high between frames; either launch the next frame or finish.
        S_GAP: begin
          if (cnt == CNT_W'(CS_GAP - 1)) begin
            cnt <= '0;
            if (scan_last) begin
              o_busy <= 1'b0;
              o_done <= 1'b1;
              state  <= S_IDLE;
            end else begin
              if (cont && stop_now) flush <= 1'b1;
              first      <= 1'b0;
              prev_addr  <= cur_addr;
              cur_addr   <= nxt_addr;
              tx         <= nxt_word;
              o_spi_dout <= nxt_word[FRAME_W-1];
              o_spi_cs   <= 1'b0;
              state      <= S_SETUP;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// tb_adc_scan_ctrl: behavioural ADC slave plus scan-sequence model for adc_scan_ctrl.
module tb_adc_scan_ctrl;

  localparam int unsigned CLK_DIV   = 4;
  localparam int unsigned DATA_W    = 12;
  localparam int unsigned CS_GAP    = 2;
  localparam int          FRAME_CYC = 17 * CLK_DIV;

  logic              i_sclk  = 1'b0;
  logic              i_rst_n = 1'b0;
  logic              i_start = 1'b0;
  logic              i_cont  = 1'b0;
  logic              i_stop  = 1'b0;
  logic [7:0]        i_ch_mask = 8'h00;
  logic              i_ready = 1'b1;
  logic              i_spi_din = 1'b0;
  logic              o_busy, o_done, o_valid, o_overrun;
  logic [DATA_W-1:0] o_data;
  logic [2:0]        o_ch;
  logic              o_spi_sclk, o_spi_cs, o_spi_dout;

  int tests = 0;
  int fails = 0;

  adc_scan_ctrl #(.CLK_DIV(CLK_DIV), .DATA_W(DATA_W), .CS_GAP(CS_GAP), .REF_BIT(0)) dut (
    .i_sclk(i_sclk), .i_rst_n(i_rst_n), .i_start(i_start), .i_cont(i_cont),
    .i_stop(i_stop), .i_ch_mask(i_ch_mask), .o_busy(o_busy), .o_done(o_done),
    .o_data(o_data), .o_ch(o_ch), .o_valid(o_valid), .i_ready(i_ready),
    .o_overrun(o_overrun), .o_spi_sclk(o_spi_sclk), .o_spi_cs(o_spi_cs),
    .o_spi_dout(o_spi_dout), .i_spi_din(i_spi_din)
  );

  always #5 i_sclk = ~i_sclk;

  // ADC slave / monitor state
  logic        table_mode = 1'b0;
  logic [11:0] chan_val [8];
  logic        prev_cs = 1'b1, prev_sclk = 1'b1;
  logic [15:0] resp_sh = '0, cur_word = '0, cw = '0;
  logic [2:0]  last_addr = '0;
  int          low_cnt = 0, rises = 0, cs_falls = 0, done_cycles = 0;
  logic [15:0] q_cw[$], q_resp[$];
  int          q_len[$], q_rise[$];
  logic [2:0]  q_rch[$];
  logic [DATA_W-1:0] q_rdat[$];

  // ADC behaviour: DOUT changes on SCLK fall, DIN captured on SCLK rise; also logs results and done.
  always @(negedge i_sclk) begin
    if (o_done) done_cycles++;
    if (o_valid && i_ready) begin
      q_rch.push_back(o_ch);
      q_rdat.push_back(o_data);
    end
    if (!o_spi_cs && prev_cs) begin
      cs_falls++;
      low_cnt  = 1;
      rises    = 0;
      cw       = '0;
      cur_word = table_mode ? {4'h0, chan_val[last_addr]} : 16'($urandom);
      resp_sh  = cur_word;
      i_spi_din = cur_word[15];
    end else if (!o_spi_cs) begin
      low_cnt++;
      if (!o_spi_sclk && prev_sclk) i_spi_din = resp_sh[15];
      if (o_spi_sclk && !prev_sclk) begin
        cw      = {cw[14:0], o_spi_dout};
        resp_sh = {resp_sh[14:0], 1'b0};
        rises++;
      end
    end else if (o_spi_cs && !prev_cs) begin
      q_cw.push_back(cw);
      q_resp.push_back(cur_word);
      q_len.push_back(low_cnt);
      q_rise.push_back(rises);
      last_addr = cw[13:11];
    end
    prev_cs   = o_spi_cs;
    prev_sclk = o_spi_sclk;
  end

  // Model: j-th frame addresses the (j mod N)-th enabled channel, ascending.
  function automatic logic [2:0] exp_addr(input logic [7:0] m, input int j);
    logic [2:0] lst [8];
    int n;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      lst[i] = 3'd0;
      if (m[i]) begin
        lst[n] = 3'(i);
        n++;
      end
    end
    return lst[j % n];
  endfunction

  function automatic int popc(input logic [7:0] m);
    int n;
    n = 0;
    for (int i = 0; i < 8; i++) n += int'(m[i]);
    return n;
  endfunction

  task automatic tick();
    @(posedge i_sclk);
    #1;
  endtask

  task automatic pulse_start(input logic [7:0] m, input logic c);
    i_ch_mask = m;
    i_cont    = c;
    i_start   = 1'b1;
    tick();
    i_start   = 1'b0;
  endtask

  task automatic wait_done(input int bound, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < bound; n++) begin
      tick();
      if (o_done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    tests++;
    if ({o_spi_cs, o_spi_sclk, o_spi_dout, o_busy, o_done, o_valid, o_overrun} !== 7'b1100000) begin
      fails++;
      $display("FAIL reset_ctrl: got %b exp 1100000", {o_spi_cs, o_spi_sclk, o_spi_dout, o_busy, o_done, o_valid, o_overrun});
    end
    tests++;
    if ({o_ch, o_data} !== 15'h0) begin
      fails++;
      $display("FAIL reset_data: got ch=%0d data=%h exp 0/000", o_ch, o_data);
    end
  endtask

  // One scan with i_ready held high; checks frames, control words and results against the model.
  task automatic test_scan(input logic [7:0] m, input logic c, input int stop_at, input string tag);
    int fb, rb, dcb, fcb, nf, nr;
    bit ok;
    logic [15:0] ew;
    fb = q_cw.size(); rb = q_rch.size(); dcb = done_cycles; fcb = cs_falls;
    i_ready = 1'b1;
    pulse_start(m, c);
    tests++;
    if ({o_busy, o_spi_cs} !== 2'b10) begin
      fails++;
      $display("FAIL %s start: busy/cs got %b exp 10", tag, {o_busy, o_spi_cs});
    end
    if (c) begin
      ok = 1'b0;
      for (int n = 0; n < (stop_at + 1) * (FRAME_CYC + 10); n++) begin
        if (cs_falls - fcb >= stop_at) begin
          ok = 1'b1;
          break;
        end
        tick();
      end
      tests++;
      if (!ok) begin
        fails++;
        $display("FAIL %s frame_wait: got %0d frames exp %0d", tag, cs_falls - fcb, stop_at);
      end
      repeat (10) tick();
      i_stop = 1'b1;
      tick();
      i_stop = 1'b0;
    end
    nf = c ? stop_at + 1 : popc(m) + 1;
    nr = nf - 1;
    wait_done(nf * (FRAME_CYC + CS_GAP) + 50, ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s done_timeout: got no done exp done within bound", tag);
    end
    tick();
    tests++;
    if (q_cw.size() - fb !== nf) begin
      fails++;
      $display("FAIL %s frames: got %0d exp %0d", tag, q_cw.size() - fb, nf);
    end
    tests++;
    if (q_rch.size() - rb !== nr) begin
      fails++;
      $display("FAIL %s results: got %0d exp %0d", tag, q_rch.size() - rb, nr);
    end
    for (int j = 0; j < nf && fb + j < q_cw.size(); j++) begin
      ew = {2'b00, exp_addr(m, j), 1'b0, 2'b00, 8'h00};
      tests++;
      if (q_cw[fb+j] !== ew || q_len[fb+j] != FRAME_CYC || q_rise[fb+j] != 16) begin
        fails++;
        $display("FAIL %s frame%0d: got word=%h len=%0d rises=%0d exp word=%h len=%0d rises=16",
                 tag, j, q_cw[fb+j], q_len[fb+j], q_rise[fb+j], ew, FRAME_CYC);
      end
    end
    for (int r = 0; r < nr && rb + r < q_rch.size() && fb + r + 1 < q_resp.size(); r++) begin
      tests++;
      if (q_rch[rb+r] !== exp_addr(m, r) || q_rdat[rb+r] !== q_resp[fb+r+1][DATA_W-1:0]) begin
        fails++;
        $display("FAIL %s result%0d: got ch=%0d data=%h exp ch=%0d data=%h", tag, r,
                 q_rch[rb+r], q_rdat[rb+r], exp_addr(m, r), q_resp[fb+r+1][DATA_W-1:0]);
      end
    end
    tests++;
    if (done_cycles - dcb != 1) begin
      fails++;
      $display("FAIL %s done_pulse: got %0d cycles exp 1", tag, done_cycles - dcb);
    end
    tests++;
    if ({o_busy, o_valid, o_overrun, o_spi_cs, o_spi_sclk} !== 5'b00011) begin
      fails++;
      $display("FAIL %s idle: busy/valid/ovr/cs/sclk got %b exp 00011", tag,
               {o_busy, o_valid, o_overrun, o_spi_cs, o_spi_sclk});
    end
  endtask

  task automatic test_single_one();
    table_mode = 1'b1;
    chan_val[0] = 12'hABC;
    test_scan(8'h01, 1'b0, 0, "t1");
    tests++;
    if (q_rch.size() == 0 || q_rdat[$] !== 12'hABC || q_rch[$] !== 3'd0) begin
      fails++;
      $display("FAIL t1_value: got ch=%0d data=%h exp 0/abc", q_rch[$], q_rdat[$]);
    end
  endtask

  task automatic test_single_two();
    int fb, rb;
    logic [7:0] b0, b1, b2;
    fb = q_cw.size(); rb = q_rch.size();
    chan_val[0] = 12'h111;
    chan_val[2] = 12'h222;
    test_scan(8'h05, 1'b0, 0, "t2");
    table_mode = 1'b0;
    if (q_cw.size() >= fb + 3 && q_rch.size() >= rb + 2) begin
      b0 = q_cw[fb][15:8]; b1 = q_cw[fb+1][15:8]; b2 = q_cw[fb+2][15:8];
      tests++;
      if ({b0, b1, b2} !== 24'h001000) begin
        fails++;
        $display("FAIL t2_din_bytes: got %h %h %h exp 00 10 00", b0, b1, b2);
      end
      tests++;
      if ({q_rch[rb], q_rdat[rb], q_rch[rb+1], q_rdat[rb+1]} !== {3'd0, 12'h111, 3'd2, 12'h222}) begin
        fails++;
        $display("FAIL t2_values: got (%0d,%h) (%0d,%h) exp (0,111) (2,222)",
                 q_rch[rb], q_rdat[rb], q_rch[rb+1], q_rdat[rb+1]);
      end
    end else begin
      tests++;
      fails++;
      $display("FAIL t2_count: got %0d frames exp 3", q_cw.size() - fb);
    end
  endtask

  task automatic test_continuous();
    test_scan(8'h81, 1'b1, 5, "t3");
  endtask

  task automatic test_overrun();
    int fb;
    bit ok;
    fb = q_cw.size();
    i_ready = 1'b0;
    pulse_start(8'h03, 1'b0);
    wait_done(4 * (FRAME_CYC + CS_GAP), ok);
    tests++;
    if (!ok || q_cw.size() - fb != 3) begin
      fails++;
      $display("FAIL ovr_scan: got done=%0d frames=%0d exp 1/3", ok, q_cw.size() - fb);
    end
    tests++;
    if ({o_valid, o_overrun, o_ch} !== {2'b11, 3'd1} || q_resp.size() < fb + 3 ||
        o_data !== q_resp[fb+2][DATA_W-1:0]) begin
      fails++;
      $display("FAIL ovr_state: got valid=%b ovr=%b ch=%0d data=%h exp 1/1/1/%h",
               o_valid, o_overrun, o_ch, o_data, q_resp[fb+2][DATA_W-1:0]);
    end
    i_ready = 1'b1;
    tick();
    tests++;
    if ({o_valid, o_overrun} !== 2'b01) begin
      fails++;
      $display("FAIL ovr_accept: valid/ovr got %b exp 01", {o_valid, o_overrun});
    end
    pulse_start(8'(($urandom_range(1, 255))), 1'b0);
    tests++;
    if ({o_busy, o_overrun} !== 2'b10) begin
      fails++;
      $display("FAIL ovr_clear: busy/ovr got %b exp 10", {o_busy, o_overrun});
    end
    wait_done(10 * (FRAME_CYC + CS_GAP), ok);
    tick();
  endtask

  task automatic test_reset_mid();
    int fcb;
    fcb = cs_falls;
    pulse_start(8'hFF, 1'b1);
    for (int n = 0; n < 20 && cs_falls == fcb; n++) tick();
    repeat (20) tick();
    #2;
    i_rst_n = 1'b0;
    #1;
    tests++;
    if ({o_spi_cs, o_spi_sclk, o_valid, o_busy, o_spi_dout} !== 5'b11000) begin
      fails++;
      $display("FAIL reset_mid: cs/sclk/valid/busy/dout got %b exp 11000",
               {o_spi_cs, o_spi_sclk, o_valid, o_busy, o_spi_dout});
    end
    repeat (2) tick();
    i_rst_n = 1'b1;
    tick();
    test_scan(8'(($urandom_range(1, 255))), 1'b0, 0, "t5_after");
  endtask

  task automatic test_zero_mask();
    int fcb, dcb;
    fcb = cs_falls; dcb = done_cycles;
    pulse_start(8'h00, 1'b0);
    tests++;
    if ({o_done, o_busy} !== 2'b10) begin
      fails++;
      $display("FAIL zero_done: done/busy got %b exp 10", {o_done, o_busy});
    end
    tick();
    tests++;
    if (o_done !== 1'b0) begin
      fails++;
      $display("FAIL zero_pulse: done got %b exp 0", o_done);
    end
    repeat (10) tick();
    tests++;
    if (cs_falls != fcb || done_cycles - dcb != 1) begin
      fails++;
      $display("FAIL zero_cs: got cs_falls=%0d done_cycles=%0d exp 0/1", cs_falls - fcb, done_cycles - dcb);
    end
  endtask

  task automatic test_back_to_back();
    int fb, rb;
    bit ok;
    fb = q_cw.size(); rb = q_rch.size();
    pulse_start(8'h01, 1'b0);
    repeat (10) tick();
    pulse_start(8'hFF, 1'b1);
    wait_done(4 * (FRAME_CYC + CS_GAP), ok);
    tick();
    tests++;
    if (!ok || q_cw.size() - fb != 2 || q_rch.size() - rb != 1 || o_busy !== 1'b0) begin
      fails++;
      $display("FAIL busy_start: got done=%0d frames=%0d results=%0d busy=%b exp 1/2/1/0",
               ok, q_cw.size() - fb, q_rch.size() - rb, o_busy);
    end
  endtask

  task automatic test_random();
    logic [7:0] m;
    logic c;
    for (int k = 0; k < 6; k++) begin
      m = 8'($urandom_range(1, 255));
      c = 1'($urandom_range(0, 1));
      test_scan(m, c, int'($urandom_range(1, 6)), "rand");
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) chan_val[i] = 12'h000;
    repeat (3) tick();
    i_rst_n = 1'b1;
    tick();
    test_reset();
    test_single_one();
    test_single_two();
    test_continuous();
    test_overrun();
    test_reset_mid();
    test_zero_mask();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish exp finish before 900us");
    $fatal(1);
  end

endmodule
